// File: rtl/jtcop_pal_arb_pkg.sv
// jtcop_pal_arb_pkg: shared types for the palette RAM arbiter.
// Sequencer states and the slot qualification helper.
package jtcop_pal_arb_pkg;

  typedef enum logic [1:0] {
    ST_CLEAR   = 2'd0,
    ST_IDLE    = 2'd1,
    ST_RD_WAIT = 2'd2,
    ST_DONE    = 2'd3
  } pal_st_e;

  // gap cycle the CPU may use: no pixel read,
  // and blanking active when blank_only is set
  function automatic logic free_slot(
    input logic cen,
    input logic blank_only,
    input logic hb,
    input logic vb
  );
    return !cen && (!blank_only || !hb || !vb);
  endfunction

endpackage

// File: rtl/jtcop_pal_arb.sv
// jtcop_pal_arb: time-slot arbiter for one palette RAM port.
// Video owns pxl_cen cycles, CPU and clear sweep use the gaps.
module jtcop_pal_arb
  import jtcop_pal_arb_pkg::*;
#(
  parameter int            AW        = 10,
  parameter int            DW        = 16,
  parameter logic [DW-1:0] CLRVAL    = '0,
  parameter bit            BLANKONLY = 1'b0
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic          pxl_cen,
  input  logic          LHBL,
  input  logic          LVBL,
  input  logic [AW-1:0] vid_addr,
  output logic [DW-1:0] vid_dout,
  input  logic          cpu_cs,
  input  logic          cpu_rnw,
  input  logic [AW-1:0] cpu_addr,
  input  logic [DW-1:0] cpu_din,
  input  logic [1:0]    cpu_dsn,
  output logic [DW-1:0] cpu_dout,
  output logic          cpu_ok,
  output logic          init_done,
  output logic [AW-1:0] ram_addr,
  output logic [DW-1:0] ram_din,
  output logic [1:0]    ram_we,
  input  logic [DW-1:0] ram_q
);

  localparam logic [AW-1:0] CNT_ONE =
    {{(AW-1){1'b0}}, 1'b1};

  pal_st_e       st_q, st_d;
  logic [AW-1:0] cnt_q, cnt_d;
  logic          init_q, init_d;
  logic          ok_q, ok_d;
  logic [DW-1:0] cdout_q, cdout_d;
  logic [DW-1:0] vdout_q;
  logic          vpend_q;
  logic          cpu_free;
  logic          clr_free;

  // the sweep only yields to video; CPU may
  // additionally be restricted to blanking
  assign cpu_free = free_slot(pxl_cen, BLANKONLY,
                              LHBL, LVBL);
  assign clr_free = !pxl_cen;

  // sequencer next state and RAM port steering
  always_comb begin
    st_d     = st_q;
    cnt_d    = cnt_q;
    init_d   = init_q;
    cdout_d  = cdout_q;
    ram_addr = vid_addr;
    ram_din  = cpu_din;
    ram_we   = 2'b00;
    unique case (st_q)
      ST_CLEAR: begin
        if (clr_free) begin
          ram_addr = cnt_q;
          ram_din  = CLRVAL;
          ram_we   = 2'b11;
          if (cnt_q == '1) begin
            init_d = 1'b1;
            st_d   = ST_IDLE;
          end else begin
            cnt_d = cnt_q + CNT_ONE;
          end
        end
      end
      ST_IDLE: begin
        if (cpu_cs && cpu_free) begin
          ram_addr = cpu_addr;
          if (cpu_rnw) begin
            st_d = ST_RD_WAIT;
          end else begin
            ram_we = ~cpu_dsn;
            st_d   = ST_DONE;
          end
        end
      end
      ST_RD_WAIT: begin
        // ram_q holds the CPU word even if
        // this cycle's address is video's
        cdout_d = ram_q;
        st_d    = cpu_cs ? ST_DONE : ST_IDLE;
      end
      ST_DONE: begin
        if (!cpu_cs) st_d = ST_IDLE;
      end
      default: st_d = ST_CLEAR;
    endcase
    ok_d = (st_d == ST_DONE);
    // keep the RAM quiet while held in reset
    if (!rst_n) begin
      ram_addr = '0;
      ram_we   = 2'b00;
    end
  end

  // sequencer registers
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      st_q    <= ST_CLEAR;
      cnt_q   <= '0;
      init_q  <= 1'b0;
      ok_q    <= 1'b0;
      cdout_q <= '0;
    end else begin
      st_q    <= st_d;
      cnt_q   <= cnt_d;
      init_q  <= init_d;
      ok_q    <= ok_d;
      cdout_q <= cdout_d;
    end
  end

  // video read: capture ram_q one cycle
  // after the pixel slot presented its address
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      vpend_q <= 1'b0;
      vdout_q <= '0;
    end else begin
      vpend_q <= pxl_cen;
      if (vpend_q) vdout_q <= ram_q;
    end
  end

  assign vid_dout  = vdout_q;
  assign cpu_dout  = cdout_q;
  assign cpu_ok    = ok_q;
  assign init_done = init_q;

endmodule
